prbs16_checker: RTL and testbench

- Downstream consumer of the 16-bit Fibonacci LFSR pattern generator (taps 15,13,12,10; shift left, feedback into bit 0).
- Self-synchronises to the incoming word stream, then predicts each next word locally and compares it against the received word.
- Reports lock status, a per-word error pulse, and saturating error and word counters.
- Sits at the end of the pattern path, used in BIST and link checks.

---
 rtl/prbs16_pkg.sv | 12 +
 rtl/prbs16_checker_sat_counter.sv | 17 +
 rtl/prbs16_checker.sv | 87 ++++++++
 tb/tb_prbs16_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/prbs16_pkg.sv
// prbs16_pkg: shared LFSR definitions for the PRBS16 generator/checker pair.
package prbs16_pkg;
  localparam int LFSR_W = 16;
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;
  typedef enum logic {HUNT, LOCKED} chk_state_t;
  function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], x[TAP_A] ^ x[TAP_B] ^ x[TAP_C] ^ x[TAP_D]};
  endfunction
endpackage

// File: rtl/prbs16_checker_sat_counter.sv
// sat_counter: saturating up-counter with priority synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) r_count <= '0;
    else if (clr) r_count <= '0;
    else if (inc && r_count != '1) r_count <= r_count + W'(1);
  assign count = r_count;
endmodule

// File: rtl/prbs16_checker.sv
// prbs16_checker: self-synchronising PRBS16 word checker with lock FSM,
// per-word error pulse and saturating error/word counters.
module prbs16_checker
  import prbs16_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  output logic              locked,
  output logic              err,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count
);
  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);
  chk_state_t        r_state;
  logic [LFSR_W-1:0] r_exp;
  logic              r_exp_vld;
  logic [HW-1:0]     r_hunt_cnt;
  logic [MW-1:0]     r_miss_cnt;
  logic              r_err;
  logic              w_match;
  logic              w_cnt_ev;
  logic              w_err_ev;
  logic [HW-1:0]     w_hunt_inc;
  logic [MW-1:0]     w_miss_inc;
  assign w_match    = in_data == r_exp;
  assign w_cnt_ev   = in_valid && r_state == LOCKED;
  assign w_err_ev   = w_cnt_ev && !w_match;
  assign w_hunt_inc = r_hunt_cnt + HW'(1);
  assign w_miss_inc = r_miss_cnt + MW'(1);
  // In HUNT the prediction is reseeded from every non-zero word; once LOCKED it free-runs.
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      r_state    <= HUNT;
      r_exp      <= '0;
      r_exp_vld  <= 1'b0;
      r_hunt_cnt <= '0;
      r_miss_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err_ev;
      if (in_valid) begin
        if (r_state == HUNT) begin
          if (in_data == '0) begin
            r_exp_vld  <= 1'b0;
            r_hunt_cnt <= '0;
          end else begin
            r_exp     <= lfsr16_next(in_data);
            r_exp_vld <= 1'b1;
            if (r_exp_vld && w_match) begin
              r_hunt_cnt <= w_hunt_inc;
              if (w_hunt_inc == HW'(LOCK_CNT)) begin
                r_state    <= LOCKED;
                r_miss_cnt <= '0;
              end
            end else r_hunt_cnt <= '0;
          end
        end else begin
          r_exp <= lfsr16_next(r_exp);
          if (w_match) r_miss_cnt <= '0;
          else begin
            r_miss_cnt <= w_miss_inc;
            if (w_miss_inc == MW'(UNLOCK_CNT)) begin
              r_state    <= HUNT;
              r_exp_vld  <= 1'b0;
              r_hunt_cnt <= '0;
            end
          end
        end
      end
    end
  assign locked = r_state == LOCKED;
  assign err    = r_err;
  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .nReset(nReset), .clr(clear), .inc(w_err_ev), .count(err_count)
  );
  sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk(clk), .nReset(nReset), .clr(clear), .inc(w_cnt_ev), .count(word_count)
  );
endmodule

// File: tb/tb_prbs16_checker.sv
// tb_prbs16_checker: randomized scenario bench against a word-level reference model.
module tb_prbs16_checker;
  localparam int LOCK_CNT = 4, UNLOCK_CNT = 3, CNT_W = 4;
  localparam int MAXC = (1 << CNT_W) - 1;
  logic clk = 0, nReset = 0, clear = 0, in_valid = 0;
  logic [15:0] in_data = '0;
  logic locked, err;
  logic [CNT_W-1:0] err_count, word_count;
  int checks = 0, errors = 0;
  bit m_locked, m_vld, m_err;
  logic [15:0] m_exp, gen;
  int m_hunt, m_miss, m_ec, m_wc;

  prbs16_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(CNT_W)) dut (
    .clk(clk), .nReset(nReset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .err(err), .err_count(err_count), .word_count(word_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_next(input logic [15:0] x);
    int xi, fb;
    xi = int'(x);
    fb = ((xi >> 15) ^ (xi >> 13) ^ (xi >> 12) ^ (xi >> 10)) & 1;
    return 16'((xi << 1) | fb);
  endfunction

  task automatic model_reset();
    m_locked = 0; m_vld = 0; m_err = 0; m_exp = '0;
    m_hunt = 0; m_miss = 0; m_ec = 0; m_wc = 0;
  endtask

  task automatic model_step(input bit v, input logic [15:0] d, input bit clr);
    m_err = 0;
    if (v && !m_locked) begin
      if (d == 16'h0) begin
        m_vld = 0; m_hunt = 0;
      end else begin
        m_hunt = (m_vld && d == m_exp) ? m_hunt + 1 : 0;
        if (m_hunt == LOCK_CNT) begin m_locked = 1; m_miss = 0; end
        m_exp = ref_next(d); m_vld = 1;
      end
    end else if (v) begin
      m_wc = (m_wc < MAXC) ? m_wc + 1 : m_wc;
      if (d == m_exp) m_miss = 0;
      else begin
        m_err = 1;
        m_ec = (m_ec < MAXC) ? m_ec + 1 : m_ec;
        m_miss++;
        if (m_miss == UNLOCK_CNT) begin m_locked = 0; m_vld = 0; m_hunt = 0; end
      end
      m_exp = ref_next(m_exp);
    end
    if (clr) begin m_ec = 0; m_wc = 0; end
  endtask

  task automatic cycle(input bit v, input logic [15:0] d, input bit clr);
    in_valid = v; in_data = d; clear = clr;
    @(posedge clk); #1;
    model_step(v, d, clr);
    in_valid = 0; clear = 0;
  endtask

  task automatic send_good();
    cycle(1, gen, 0);
    gen = ref_next(gen);
  endtask

  task automatic send_bad(input logic [15:0] flip);
    cycle(1, gen ^ flip, 0);
    gen = ref_next(gen);
  endtask

  task automatic test_reset();
    nReset = 0; #2;
    checks++;
    if ({locked, err, err_count, word_count} !== '0) begin
      errors++; $display("FAIL reset: got %b%b %h %h want all zero", locked, err, err_count, word_count);
    end
    @(posedge clk); #1; nReset = 1; model_reset();
  endtask

  task automatic test_acquire();
    gen = 16'hACE1;
    for (int i = 0; i < 5; i++) begin
      send_good();
      checks += 2;
      if ({locked, err, err_count, word_count} !== {m_locked, m_err, CNT_W'(m_ec), CNT_W'(m_wc)}) begin
        errors++; $display("FAIL acquire_model w%0d: got %b%b %h %h want %b%b %h %h", i, locked, err, err_count, word_count, m_locked, m_err, m_ec, m_wc);
      end
      if (locked !== (i == 4)) begin
        errors++; $display("FAIL acquire_lock w%0d: got %b want %b", i, locked, i == 4);
      end
    end
  endtask

  task automatic test_single_corrupt();
    cycle(0, 16'h0, 1);
    send_good(); send_good();
    send_bad(16'h0001);
    checks++;
    if ({locked, err, err_count} !== {1'b1, 1'b1, CNT_W'(1)}) begin
      errors++; $display("FAIL corrupt_pulse: got l%b e%b c%h want l1 e1 c1", locked, err, err_count);
    end
    for (int i = 0; i < 4; i++) begin
      send_good();
      checks++;
      if ({locked, err, err_count, word_count} !== {m_locked, m_err, CNT_W'(m_ec), CNT_W'(m_wc)} || err !== 1'b0) begin
        errors++; $display("FAIL corrupt_after w%0d: got %b%b %h %h want %b%b %h %h", i, locked, err, err_count, word_count, m_locked, m_err, m_ec, m_wc);
      end
    end
  endtask

  task automatic test_loss_sync();
    int ec0;
    ec0 = int'(err_count);
    for (int i = 0; i < 3; i++) begin
      send_bad(16'h8000);
      checks++;
      if (locked !== (i < 2) || err !== 1'b1) begin
        errors++; $display("FAIL unlock w%0d: got l%b e%b want l%b e1", i, locked, err, i < 2);
      end
    end
    checks++;
    if (int'(err_count) !== ec0 + 3 || err_count !== CNT_W'(m_ec)) begin
      errors++; $display("FAIL unlock_count: got %0d want %0d", err_count, ec0 + 3);
    end
    gen = 16'($urandom_range(1, 65535));
    for (int i = 0; i < 5; i++) begin
      send_good();
      checks++;
      if (locked !== (i == 4) || locked !== m_locked) begin
        errors++; $display("FAIL relock w%0d: got %b want %b", i, locked, i == 4);
      end
    end
  endtask

  task automatic test_zero();
    nReset = 0; #1; nReset = 1; model_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1, 16'h0, 0);
      checks++;
      if (locked !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL zero_hunt w%0d: got l%b e%b want l0 e0", i, locked, err);
      end
    end
    gen = 16'($urandom_range(1, 65535));
    for (int i = 0; i < 5; i++) begin
      send_good();
      checks++;
      if (locked !== (i == 4)) begin
        errors++; $display("FAIL zero_relock w%0d: got %b want %b", i, locked, i == 4);
      end
    end
  endtask

  task automatic test_saturation();
    cycle(0, 16'h0, 1);
    for (int i = 0; i < 27; i++) begin
      if (i % 3 != 2) send_bad(16'(1 << $urandom_range(0, 15)));
      else send_good();
      checks++;
      if ({locked, err, err_count, word_count} !== {m_locked, m_err, CNT_W'(m_ec), CNT_W'(m_wc)}) begin
        errors++; $display("FAIL sat_model w%0d: got %b%b %h %h want %b%b %h %h", i, locked, err, err_count, word_count, m_locked, m_err, m_ec, m_wc);
      end
    end
    checks++;
    if (err_count !== 4'hF || word_count !== 4'hF) begin
      errors++; $display("FAIL sat_hold: got %h %h want f f", err_count, word_count);
    end
  endtask

  task automatic test_clear_with_err();
    cycle(1, gen ^ 16'h0001, 1);
    gen = ref_next(gen);
    checks++;
    if ({err, err_count, word_count} !== {1'b1, CNT_W'(0), CNT_W'(0)} || locked !== m_locked) begin
      errors++; $display("FAIL clear_err: got e%b %h %h want e1 0 0", err, err_count, word_count);
    end
  endtask

  task automatic test_async_reset();
    send_good(); send_bad(16'h0100);
    #3 nReset = 0;
    #1;
    checks++;
    if ({locked, err, err_count, word_count} !== '0) begin
      errors++; $display("FAIL async_reset: got %b%b %h %h want all zero", locked, err, err_count, word_count);
    end
    model_reset();
    @(posedge clk); #1; nReset = 1;
  endtask

  task automatic test_gaps();
    gen = 16'($urandom_range(1, 65535));
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0) send_good();
      else cycle(0, 16'($urandom), 0);
      checks++;
      if ({locked, err, err_count, word_count} !== {m_locked, m_err, CNT_W'(m_ec), CNT_W'(m_wc)}) begin
        errors++; $display("FAIL gaps_model w%0d: got %b%b %h %h want %b%b %h %h", i, locked, err, err_count, word_count, m_locked, m_err, m_ec, m_wc);
      end
    end
    checks++;
    if (locked !== 1'b1 || err_count !== '0) begin
      errors++; $display("FAIL gaps_final: got l%b c%h want l1 c0", locked, err_count);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_acquire();
    test_single_corrupt();
    test_loss_sync();
    test_zero();
    test_saturation();
    test_clear_with_err();
    test_async_reset();
    test_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
